// File: rtl/dm_lsu_seq.sv
// Load/store sequencer for the 4 KB data memory; halfwords become two byte ops.
// Optional misalignment check enabled by defining DM_LSU_ALIGN_CHECK_EN.
module dm_lsu_seq #(
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [DM_AW-1:0] dm_addr,
  output logic [1:0]       dm_byte_off,
  output logic             dm_op_type,
  output logic             dm_ext_type,
  output logic             dm_wr_en,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic        half_q;
  logic        signed_q;
  logic [1:0]  addr_q;
  logic [7:0]  wdata_hi_q;
  logic [7:0]  lo_q;
  logic        err_q;

  logic        req_word;
  logic        req_half;
  logic        misalign;
  logic        unused_addr;

  assign req_word  = req_size[1];
  assign req_half  = (req_size == 2'b01);
  assign req_ready = (state_q == IDLE) & ~rst;
  assign resp_err  = err_q;

  assign unused_addr = ^req_addr[31:DM_AW+2];

`ifdef DM_LSU_ALIGN_CHECK_EN
  assign misalign = (req_word & (|req_addr[1:0]))
                  | (req_half & req_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      half_q      <= 1'b0;
      signed_q    <= 1'b0;
      addr_q      <= 2'b00;
      wdata_hi_q  <= 8'h00;
      lo_q        <= 8'h00;
      err_q       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      dm_addr     <= '0;
      dm_byte_off <= 2'b00;
      dm_op_type  <= 1'b0;
      dm_ext_type <= 1'b0;
      dm_wr_en    <= 1'b0;
      dm_wdata    <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            half_q      <= req_half;
            signed_q    <= req_signed;
            addr_q      <= req_addr[1:0];
            wdata_hi_q  <= req_wdata[15:8];
            resp_rdata  <= 32'h0;
            err_q       <= misalign;
            dm_addr     <= req_addr[DM_AW+1:2];
            dm_wdata    <= req_wdata;
            dm_ext_type <= 1'b0;
            // Memory outputs are registered, so the first access is set up here.
            if (misalign) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              dm_wr_en   <= 1'b0;
            end else begin
              state_q  <= ACC0;
              dm_wr_en <= req_we;
              if (req_word) begin
                dm_op_type  <= 1'b1;
                dm_byte_off <= 2'b00;
              end else if (req_half) begin
                dm_op_type  <= 1'b0;
                dm_byte_off <= {req_addr[1], 1'b0};
              end else begin
                dm_op_type  <= 1'b0;
                dm_byte_off <= req_addr[1:0];
                dm_ext_type <= req_signed;
              end
            end
          end
        end
        ACC0: begin
          if (half_q) begin
            state_q     <= ACC1;
            lo_q        <= dm_rdata[7:0];
            dm_byte_off <= {addr_q[1], 1'b1};
            dm_wdata    <= {24'h0, wdata_hi_q};
            dm_wr_en    <= we_q;
          end else begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? 32'h0 : dm_rdata;
            dm_wr_en   <= 1'b0;
          end
        end
        ACC1: begin
          state_q    <= RESP;
          resp_valid <= 1'b1;
          dm_wr_en   <= 1'b0;
          if (!we_q) begin
            resp_rdata <= {{16{signed_q & dm_rdata[7]}},
                           dm_rdata[7:0], lo_q};
          end
        end
        RESP: begin
          state_q    <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu_seq.sv
// Directed bench for dm_lsu_seq with a behavioural 4 KB data memory.
module tb_dm_lsu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  dm_addr;
  logic [1:0]  dm_byte_off;
  logic        dm_op_type;
  logic        dm_ext_type;
  logic        dm_wr_en;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  dm_lsu_seq #(.DM_AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .dm_addr     (dm_addr),
    .dm_byte_off (dm_byte_off),
    .dm_op_type  (dm_op_type),
    .dm_ext_type (dm_ext_type),
    .dm_wr_en    (dm_wr_en),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata)
  );

  logic [31:0] rd_word;
  logic [7:0]  rd_lane;
  always_comb begin
    rd_word  = mem[dm_addr];
    rd_lane  = rd_word[8*dm_byte_off +: 8];
    dm_rdata = dm_op_type ? rd_word
                          : {{24{dm_ext_type & rd_lane[7]}}, rd_lane};
  end

  always @(posedge clk) begin
    if (dm_wr_en) begin
      if (dm_op_type) mem[dm_addr] <= dm_wdata;
      else mem[dm_addr][8*dm_byte_off +: 8] <= dm_wdata[7:0];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_np;
    logic [1:0]  exp_off0;
    logic [7:0]  exp_b0;
    logic        exp_op0;
    logic [1:0]  exp_off1;
    logic [7:0]  exp_b1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t t, input int idx);
    int         n;
    int         np;
    bit         got;
    logic [1:0] off [2];
    logic [7:0] wb [2];
    logic       op0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = t.we;
    req_size   = t.size;
    req_signed = t.sgn;
    req_addr   = t.addr;
    req_wdata  = t.wdata;
    chk($sformatf("v%0d.ready", idx), {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    got = 1'b0;
    n   = 0;
    np  = 0;
    op0 = 1'b0;
    off[0] = 2'b00; off[1] = 2'b00;
    wb[0]  = 8'h00; wb[1]  = 8'h00;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (dm_wr_en) begin
        if (np < 2) begin
          off[np] = dm_byte_off;
          wb[np]  = dm_wdata[7:0];
          if (np == 0) op0 = dm_op_type;
        end
        np++;
      end
      if (resp_valid) got = 1'b1;
      else if (n == 1)
        chk($sformatf("v%0d.clear", idx), {resp_err, resp_rdata[30:0]}, 32'h0);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL v%0d.timeout: got no resp expected resp", idx);
    end
    chk($sformatf("v%0d.rdata", idx), resp_rdata, t.exp_rdata);
    chk($sformatf("v%0d.err", idx), {31'h0, resp_err}, {31'h0, t.exp_err});
    chk($sformatf("v%0d.lat", idx), n, t.exp_lat);
    chk($sformatf("v%0d.npulse", idx), np, t.exp_np);
    if (t.exp_np >= 1 && np >= 1) begin
      chk($sformatf("v%0d.off0", idx), {30'h0, off[0]}, {30'h0, t.exp_off0});
      chk($sformatf("v%0d.b0", idx), {24'h0, wb[0]}, {24'h0, t.exp_b0});
      chk($sformatf("v%0d.op0", idx), {31'h0, op0}, {31'h0, t.exp_op0});
    end
    if (t.exp_np == 2 && np == 2) begin
      chk($sformatf("v%0d.off1", idx), {30'h0, off[1]}, {30'h0, t.exp_off1});
      chk($sformatf("v%0d.b1", idx), {24'h0, wb[1]}, {24'h0, t.exp_b1});
    end
  endtask

  vec_t v [14];
  vec_t ld10;

  initial begin
    int r1;
    int r2;
    bit pre_resp;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        rdy [1:8];

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    //        we  sz     s   addr      wdata         exp_rdata     err lat np off0  b0    op  off1  b1
    v[0]  = '{1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 1, 2'd0, 8'hEF, 1, 2'd0, 8'h00};
    v[1]  = '{0, 2'd2, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
    v[2]  = '{1, 2'd0, 0, 32'h13,   32'hFFFFFFA5, 32'h0,        0, 2, 1, 2'd3, 8'hA5, 0, 2'd0, 8'h00};
    v[3]  = '{0, 2'd0, 1, 32'h13,   32'h0,        32'hFFFFFFA5, 0, 2, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
    v[4]  = '{0, 2'd0, 0, 32'h13,   32'h0,        32'h000000A5, 0, 2, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
    v[5]  = '{0, 2'd2, 0, 32'h10,   32'h0,        32'hA5ADBEEF, 0, 2, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
    v[6]  = '{1, 2'd1, 0, 32'h22,   32'h00008001, 32'h0,        0, 3, 2, 2'd2, 8'h01, 0, 2'd3, 8'h80};
    v[7]  = '{0, 2'd1, 1, 32'h22,   32'h0,        32'hFFFF8001, 0, 3, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
    v[8]  = '{0, 2'd1, 0, 32'h22,   32'h0,        32'h00008001, 0, 3, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
`ifdef DM_LSU_ALIGN_CHECK_EN
    v[9]  = '{0, 2'd2, 0, 32'h11,   32'h0,        32'h0,        1, 1, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
`else
    v[9]  = '{0, 2'd2, 0, 32'h11,   32'h0,        32'hA5ADBEEF, 0, 2, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
`endif
    v[10] = '{1, 2'd3, 0, 32'h40,   32'h11223344, 32'h0,        0, 2, 1, 2'd0, 8'h44, 1, 2'd0, 8'h00};
    v[11] = '{0, 2'd2, 0, 32'h1010, 32'h0,        32'hA5ADBEEF, 0, 2, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
    v[12] = '{0, 2'd3, 1, 32'h40,   32'h0,        32'h11223344, 0, 2, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};
    v[13] = '{0, 2'd1, 1, 32'h20,   32'h0,        32'h00000000, 0, 3, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst.ready", {31'h0, req_ready}, 32'h0);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.wr_en", {31'h0, dm_wr_en}, 32'h0);
    chk("rst.rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 14; i++) do_req(v[i], i);

    // Reset during ACC0 of a word store
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h10;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort.wr_pre", {31'h0, dm_wr_en}, 32'h1);
    rst = 1'b1;
    #1;
    chk("abort.wr_drop", {31'h0, dm_wr_en}, 32'h0);
    chk("abort.ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("abort.ready_hold", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pre_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) pre_resp = 1'b1;
    end
    chk("abort.no_resp", {31'h0, pre_resp}, 32'h0);
    ld10 = v[5];
    do_req(ld10, 100);

    // Back-to-back word loads with req_valid held high
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    @(posedge clk);
    r1 = 0;
    r2 = 0;
    d1 = 32'h0;
    d2 = 32'h0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      rdy[n] = req_ready;
      if (resp_valid) begin
        if (r1 == 0) begin r1 = n; d1 = resp_rdata; end
        else if (r2 == 0) begin r2 = n; d2 = resp_rdata; end
      end
      if (n == 1) req_addr = 32'h40;
      if (n == 4) req_valid = 1'b0;
    end
    chk("b2b.ready_acc0", {31'h0, rdy[1]}, 32'h0);
    chk("b2b.ready_resp", {31'h0, rdy[2]}, 32'h0);
    chk("b2b.ready_idle", {31'h0, rdy[3]}, 32'h1);
    chk("b2b.ready_acc0b", {31'h0, rdy[4]}, 32'h0);
    chk("b2b.resp1_cyc", r1, 2);
    chk("b2b.resp1_data", d1, 32'hA5ADBEEF);
    chk("b2b.resp2_cyc", r2, 5);
    chk("b2b.resp2_data", d2, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
